// File: rtl/split_bus_arbiter.sv
// split_bus_arbiter: 2:1 arbiter sharing one split-transaction target between
// two hosts; outstanding read IDs are queued so in-order responses are routed
// back to the host that issued them.
module split_bus_arbiter #(
  parameter string       PRIORITY      = "RR",
  parameter int unsigned RESP_FIFO_POW = 3,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     h0_req,
  output logic                     h0_ack,
  input  logic                     h0_we,
  input  logic [ADDR_W-1:0]        h0_addr,
  input  logic [DATA_W-1:0]        h0_wdata,
  input  logic [DATA_W/8-1:0]      h0_be,
  output logic                     h0_resp,
  output logic [DATA_W-1:0]        h0_rdata,
  input  logic                     h1_req,
  output logic                     h1_ack,
  input  logic                     h1_we,
  input  logic [ADDR_W-1:0]        h1_addr,
  input  logic [DATA_W-1:0]        h1_wdata,
  input  logic [DATA_W/8-1:0]      h1_be,
  output logic                     h1_resp,
  output logic [DATA_W-1:0]        h1_rdata,
  output logic                     target_req,
  input  logic                     target_ack,
  output logic                     target_we,
  output logic [ADDR_W-1:0]        target_addr,
  output logic [DATA_W-1:0]        target_wdata,
  output logic [DATA_W/8-1:0]      target_be,
  input  logic                     target_resp,
  input  logic [DATA_W-1:0]        target_rdata,
  output logic [RESP_FIFO_POW:0]   outstanding_o,
  output logic                     err_o
);

  localparam int unsigned DEPTH   = 1 << RESP_FIFO_POW;
  localparam int unsigned PW      = RESP_FIFO_POW + 1;
  localparam bit          PRIO_H1 = (PRIORITY == "H1");

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t                   state, state_nxt;
  logic                     lock_host;
  logic                     rr_last;
  logic [DEPTH-1:0]         id_mem;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic                     err_q;

  logic                     gnt;
  logic                     g_req, g_we;
  logic [PW-1:0]            count, count_after_pop;
  logic                     empty, pop, push, accept, full_eff, head;

  // Grant selection: a locked grant is held, otherwise arbitrate by policy
  always_comb begin
    gnt = 1'b0;
    if (state == ST_LOCK) begin
      gnt = lock_host;
    end else if (h0_req && h1_req) begin
      gnt = PRIO_H1 ? 1'b1 : ~rr_last;
    end else if (h1_req) begin
      gnt = 1'b1;
    end
  end

  // Zero-latency forwarding of the granted host; reads stall on a full ID FIFO
  always_comb begin
    g_req           = gnt ? h1_req   : h0_req;
    g_we            = gnt ? h1_we    : h0_we;
    target_we       = g_we;
    target_addr     = gnt ? h1_addr  : h0_addr;
    target_wdata    = gnt ? h1_wdata : h0_wdata;
    target_be       = gnt ? h1_be    : h0_be;
    count           = wr_ptr - rd_ptr;
    empty           = (count == '0);
    pop             = target_resp && !empty;
    count_after_pop = count - PW'(pop);
    full_eff        = (count_after_pop == PW'(DEPTH));
    target_req      = rst_i && g_req && !(!g_we && full_eff);
    accept          = target_req && target_ack;
    push            = accept && !g_we;
    h0_ack          = accept && !gnt;
    h1_ack          = accept && gnt;
    head            = id_mem[rd_ptr[RESP_FIFO_POW-1:0]];
    h0_resp         = rst_i && pop && !head;
    h1_resp         = rst_i && pop && head;
    h0_rdata        = target_rdata;
    h1_rdata        = target_rdata;
    outstanding_o   = count;
    err_o           = err_q;
  end

  // Lock FSM next state: lock when the target stalls a request, release on accept
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (target_req && !target_ack) state_nxt = ST_LOCK;
      ST_LOCK: if (accept) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Lock FSM state register and locked host
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      lock_host <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && target_req && !target_ack) lock_host <= gnt;
    end
  end

  // Round-robin history, ID FIFO and sticky error flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_last <= 1'b1;
      id_mem  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) rr_last <= gnt;
      if (push) begin
        id_mem[wr_ptr[RESP_FIFO_POW-1:0]] <= gnt;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (target_resp && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_split_bus_arbiter.sv
// tb_split_bus_arbiter: directed, table-driven bench for split_bus_arbiter with
// one round-robin and one host-1-priority instance sharing the same stimulus.
module tb_split_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        h0_req, h0_we, h1_req, h1_we;
  logic [31:0] h0_addr, h0_wdata, h1_addr, h1_wdata;
  logic [3:0]  h0_be, h1_be;
  logic        target_ack, target_resp;
  logic [31:0] target_rdata;

  logic        r_h0_ack, r_h1_ack, r_h0_resp, r_h1_resp, r_treq, r_twe, r_err;
  logic [31:0] r_h0_rdata, r_h1_rdata, r_taddr, r_twdata;
  logic [3:0]  r_tbe, r_out;
  logic        p_h0_ack, p_h1_ack, p_h0_resp, p_h1_resp, p_treq, p_twe, p_err;
  logic [31:0] p_h0_rdata, p_h1_rdata, p_taddr, p_twdata;
  logic [3:0]  p_tbe, p_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  split_bus_arbiter #(.PRIORITY("RR")) u_rr (
    .clk_i(clk_i), .rst_i(rst_i),
    .h0_req(h0_req), .h0_ack(r_h0_ack), .h0_we(h0_we), .h0_addr(h0_addr),
    .h0_wdata(h0_wdata), .h0_be(h0_be), .h0_resp(r_h0_resp), .h0_rdata(r_h0_rdata),
    .h1_req(h1_req), .h1_ack(r_h1_ack), .h1_we(h1_we), .h1_addr(h1_addr),
    .h1_wdata(h1_wdata), .h1_be(h1_be), .h1_resp(r_h1_resp), .h1_rdata(r_h1_rdata),
    .target_req(r_treq), .target_ack(target_ack), .target_we(r_twe),
    .target_addr(r_taddr), .target_wdata(r_twdata), .target_be(r_tbe),
    .target_resp(target_resp), .target_rdata(target_rdata),
    .outstanding_o(r_out), .err_o(r_err)
  );

  split_bus_arbiter #(.PRIORITY("H1")) u_h1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .h0_req(h0_req), .h0_ack(p_h0_ack), .h0_we(h0_we), .h0_addr(h0_addr),
    .h0_wdata(h0_wdata), .h0_be(h0_be), .h0_resp(p_h0_resp), .h0_rdata(p_h0_rdata),
    .h1_req(h1_req), .h1_ack(p_h1_ack), .h1_we(h1_we), .h1_addr(h1_addr),
    .h1_wdata(h1_wdata), .h1_be(h1_be), .h1_resp(p_h1_resp), .h1_rdata(p_h1_rdata),
    .target_req(p_treq), .target_ack(target_ack), .target_we(p_twe),
    .target_addr(p_taddr), .target_wdata(p_twdata), .target_be(p_tbe),
    .target_resp(target_resp), .target_rdata(target_rdata),
    .outstanding_o(p_out), .err_o(p_err)
  );

  typedef struct {
    logic        h0_req, h0_we, h1_req, h1_we, ack;
    logic        e_h0_ack, e_h1_ack, e_treq;
    logic [31:0] e_addr;
    logic        e_p_h0_ack, e_p_h1_ack;
    logic [31:0] e_p_addr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    h0_req = 0; h0_we = 0; h1_req = 0; h1_we = 0;
    target_ack = 0; target_resp = 0; target_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    next_cycle();
  endtask

  initial begin
    h0_addr = 32'h100; h1_addr = 32'h200;
    h0_wdata = 32'hA0A0A0A0; h1_wdata = 32'hB1B1B1B1;
    h0_be = 4'hF; h1_be = 4'h3;
    idle_inputs();

    // Reset: outputs quiet even with a request and ack present
    rst_i = 1'b0;
    h0_req = 1; target_ack = 1; target_resp = 1;
    #3;
    chk("reset_h0_ack", 32'(r_h0_ack), 0);
    chk("reset_h0_resp", 32'(r_h0_resp), 0);
    chk("reset_outstanding", 32'(r_out), 0);
    chk("reset_err", 32'(r_err), 0);
    do_reset();

    // Write-only grant/forwarding vectors
    //            h0r h0w h1r h1w ack  rA0 rA1 rtq raddr    pA0 pA1 paddr
    vecs[0] = '{1, 1, 0, 1, 1,  1, 0, 1, 32'h100,  1, 0, 32'h100};
    vecs[1] = '{1, 1, 1, 1, 1,  0, 1, 1, 32'h200,  0, 1, 32'h200};
    vecs[2] = '{1, 1, 1, 1, 1,  1, 0, 1, 32'h100,  0, 1, 32'h200};
    vecs[3] = '{0, 1, 1, 1, 1,  0, 1, 1, 32'h200,  0, 1, 32'h200};
    vecs[4] = '{1, 1, 1, 1, 0,  0, 0, 1, 32'h100,  0, 0, 32'h200};
    vecs[5] = '{1, 1, 1, 1, 1,  1, 0, 1, 32'h100,  0, 1, 32'h200};
    vecs[6] = '{0, 1, 0, 1, 1,  0, 0, 0, 32'h100,  0, 0, 32'h100};
    for (int i = 0; i < 7; i++) begin
      h0_req = vecs[i].h0_req; h0_we = vecs[i].h0_we;
      h1_req = vecs[i].h1_req; h1_we = vecs[i].h1_we;
      target_ack = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d_rr_h0_ack", i), 32'(r_h0_ack), 32'(vecs[i].e_h0_ack));
      chk($sformatf("vec%0d_rr_h1_ack", i), 32'(r_h1_ack), 32'(vecs[i].e_h1_ack));
      chk($sformatf("vec%0d_rr_treq", i), 32'(r_treq), 32'(vecs[i].e_treq));
      chk($sformatf("vec%0d_rr_addr", i), r_taddr, vecs[i].e_addr);
      chk($sformatf("vec%0d_h1_h0_ack", i), 32'(p_h0_ack), 32'(vecs[i].e_p_h0_ack));
      chk($sformatf("vec%0d_h1_h1_ack", i), 32'(p_h1_ack), 32'(vecs[i].e_p_h1_ack));
      chk($sformatf("vec%0d_h1_addr", i), p_taddr, vecs[i].e_p_addr);
      if (vecs[i].e_treq && vecs[i].e_addr == 32'h200) begin
        chk($sformatf("vec%0d_rr_wdata", i), r_twdata, 32'hB1B1B1B1);
        chk($sformatf("vec%0d_rr_be", i), 32'(r_tbe), 32'h3);
      end
      next_cycle();
    end
    chk("writes_no_push", 32'(r_out), 0);

    // Single host-0 read, two-cycle target latency
    do_reset();
    h0_req = 1; h0_we = 0; target_ack = 1;
    #1;
    chk("rd_h0_ack", 32'(r_h0_ack), 1);
    chk("rd_twe", 32'(r_twe), 0);
    next_cycle();
    idle_inputs();
    #1;
    chk("rd_out_1", 32'(r_out), 1);
    next_cycle();
    target_resp = 1; target_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_h0_resp", 32'(r_h0_resp), 1);
    chk("rd_h0_rdata", r_h0_rdata, 32'hDEADBEEF);
    chk("rd_h1_resp", 32'(r_h1_resp), 0);
    next_cycle();
    idle_inputs();
    #1;
    chk("rd_out_0", 32'(r_out), 0);
    chk("rd_no_err", 32'(r_err), 0);

    // Round-robin continuous reads alternate and responses route in order
    do_reset();
    h0_req = 1; h1_req = 1; h0_we = 0; h1_we = 0; target_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_grant%0d_h0", i), 32'(r_h0_ack), 32'((i % 2) == 0));
      chk($sformatf("rr_grant%0d_h1", i), 32'(r_h1_ack), 32'((i % 2) == 1));
      next_cycle();
    end
    idle_inputs();
    #1;
    chk("rr_out_4", 32'(r_out), 4);
    for (int i = 0; i < 4; i++) begin
      target_resp = 1; target_rdata = 32'(i + 32'h50);
      #1;
      chk($sformatf("rr_resp%0d_h0", i), 32'(r_h0_resp), 32'((i % 2) == 0));
      chk($sformatf("rr_resp%0d_h1", i), 32'(r_h1_resp), 32'((i % 2) == 1));
      if ((i % 2) == 1) chk($sformatf("rr_rdata%0d", i), r_h1_rdata, 32'(i + 32'h50));
      next_cycle();
    end
    target_resp = 0;
    #1;
    chk("rr_out_0", 32'(r_out), 0);

    // H1 priority with a three-cycle ack stall: host 1 held, host 0 blocked
    do_reset();
    h0_req = 1; h1_req = 1; h0_we = 0; h1_we = 0; target_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("lock%0d_addr", i), p_taddr, 32'h200);
      chk($sformatf("lock%0d_treq", i), 32'(p_treq), 1);
      chk($sformatf("lock%0d_h0_ack", i), 32'(p_h0_ack), 0);
      next_cycle();
    end
    target_ack = 1;
    #1;
    chk("lock_rel_h1_ack", 32'(p_h1_ack), 1);
    chk("lock_rel_h0_ack", 32'(p_h0_ack), 0);
    next_cycle();
    idle_inputs();
    #1;
    chk("lock_out", 32'(p_out), 1);

    // Fill the ID FIFO; reads stall, writes pass, push+pop when full is legal
    do_reset();
    h0_req = 1; h0_we = 0; target_ack = 1;
    repeat (8) next_cycle();
    chk("full_out_8", 32'(r_out), 8);
    chk("full_rd_stall", 32'(r_treq), 0);
    chk("full_rd_no_ack", 32'(r_h0_ack), 0);
    next_cycle();
    h0_we = 1;
    #1;
    chk("full_wr_treq", 32'(r_treq), 1);
    chk("full_wr_ack", 32'(r_h0_ack), 1);
    next_cycle();
    h0_we = 0; target_resp = 1; target_rdata = 32'h12345678;
    #1;
    chk("full_pp_treq", 32'(r_treq), 1);
    chk("full_pp_ack", 32'(r_h0_ack), 1);
    chk("full_pp_resp", 32'(r_h0_resp), 1);
    next_cycle();
    idle_inputs();
    #1;
    chk("full_pp_out", 32'(r_out), 8);

    // Response with nothing outstanding: dropped, sticky error
    do_reset();
    target_resp = 1; target_rdata = 32'hCAFEF00D;
    #1;
    chk("orphan_h0_resp", 32'(r_h0_resp), 0);
    chk("orphan_h1_resp", 32'(r_h1_resp), 0);
    next_cycle();
    target_resp = 0;
    #1;
    chk("orphan_err", 32'(r_err), 1);
    repeat (3) next_cycle();
    chk("orphan_err_sticky", 32'(r_err), 1);
    chk("orphan_out", 32'(r_out), 0);
    rst_i = 1'b0;
    #1;
    chk("orphan_err_cleared", 32'(r_err), 0);
    rst_i = 1'b1;

    // Asynchronous reset with reads in flight, then a stale response
    do_reset();
    h0_req = 1; h0_we = 0; target_ack = 1;
    repeat (3) next_cycle();
    idle_inputs();
    #1;
    chk("async_out_3", 32'(r_out), 3);
    #1;
    rst_i = 1'b0;
    #1;
    chk("async_out_0", 32'(r_out), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    next_cycle();
    chk("async_no_err", 32'(r_err), 0);
    target_resp = 1;
    #1;
    chk("async_stale_no_resp", 32'(r_h0_resp), 0);
    next_cycle();
    target_resp = 0;
    #1;
    chk("async_stale_err", 32'(r_err), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
